bypass_net: RTL and testbench

Parametrised operand-bypass and load-use hazard unit for the in-order pipeline. It sits beside EX and supplies NUM_RS source operands each cycle. The value comes from the youngest in-flight producer among NUM_SRC stages, from a history of recently retired writes, from a regfile capture held across EX stalls, or from the live regfile read. It stalls EX when a matching producer's data is not yet ready, such as an outstanding load. It latches that data on arrival so the stall can release without losing it.

---
 rtl/bypass_pkg.sv | 19 +
 rtl/bypass_if.sv | 35 +++
 rtl/bypass_port.sv | 127 ++++++++++++
 rtl/bypass_net.sv | 82 ++++++++
 tb/tb_bypass_net.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bypass_pkg.sv
// Shared types and defaults for the EX operand bypass network.
package bypass_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_AREG = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_e;

    // One retired regfile write remembered for forwarding.
    typedef struct packed {
        logic                valid;
        logic [DEF_AREG-1:0] addr;
        logic [DEF_XLEN-1:0] data;
    } hist_entry_t;

endpackage

// File: rtl/bypass_if.sv
// Pipeline-side bundle of the bypass network: operand ports, producers, retire, stall/flush.
interface bypass_if #(
    parameter int XLEN    = bypass_pkg::DEF_XLEN,
    parameter int AREG    = bypass_pkg::DEF_AREG,
    parameter int NUM_RS  = 2,
    parameter int NUM_SRC = 2
);
    logic [NUM_RS-1:0][AREG-1:0]  rs_addr;
    logic [NUM_RS-1:0][XLEN-1:0]  rs_data_rf;
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0][AREG-1:0] src_rd_addr;
    logic [NUM_SRC-1:0][XLEN-1:0] src_rd_data;
    logic [NUM_SRC-1:0]           src_ready;
    logic                         retire_valid;
    logic [AREG-1:0]              retire_addr;
    logic [XLEN-1:0]              retire_data;
    logic                         stall_ex;
    logic                         flush;
    logic [NUM_RS-1:0][XLEN-1:0]  rs_data_ex;
    logic                         hazard_stall;
    logic [NUM_RS-1:0]            hold_active;

    modport master (
        output rs_addr, rs_data_rf, src_valid, src_rd_addr, src_rd_data, src_ready,
               retire_valid, retire_addr, retire_data, stall_ex, flush,
        input  rs_data_ex, hazard_stall, hold_active
    );

    modport slave (
        input  rs_addr, rs_data_rf, src_valid, src_rd_addr, src_rd_data, src_ready,
               retire_valid, retire_addr, retire_data, stall_ex, flush,
        output rs_data_ex, hazard_stall, hold_active
    );

endinterface

// File: rtl/bypass_port.sv
// One operand port: priority resolution mux plus the hold FSM that keeps
// forwarded producer data alive while EX is stalled.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | operand resolved live from src / history / capture / regfile
//   HOLD  | forwarded value latched during a stall; served until EX moves
module bypass_port
    import bypass_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int AREG       = DEF_AREG,
    parameter int NUM_SRC    = 2,
    parameter int HIST_DEPTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AREG-1:0]              addr,
    input  logic [XLEN-1:0]              rf_data,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC-1:0][AREG-1:0] src_rd_addr,
    input  logic [NUM_SRC-1:0][XLEN-1:0] src_rd_data,
    input  logic [NUM_SRC-1:0]           src_ready,
    input  hist_entry_t                  hist [HIST_DEPTH],
    input  logic                         cap_valid,
    input  logic [XLEN-1:0]              cap_data,
    input  logic                         stall_ex,
    input  logic                         flush,
    output logic [XLEN-1:0]              data,
    output logic                         pending,
    output logic                         hold_active
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [0:0]      state;
    logic [XLEN-1:0] hold_data;

    logic            src_hit;
    logic            src_rdy;
    logic [XLEN-1:0] src_val;
    logic            hist_hit;
    logic [XLEN-1:0] hist_val;
    logic            aux_ok;
    logic            in_hold;
    logic            fwd_ready;

    // Youngest (lowest index) matching producer alone decides the port.
    always_comb begin
        src_hit = 1'b0;
        src_rdy = 1'b0;
        src_val = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!src_hit && src_valid[i] && (src_rd_addr[i] == addr)) begin
                src_hit = 1'b1;
                src_rdy = src_ready[i];
                src_val = src_rd_data[i];
            end
        end
    end

    always_comb begin
        hist_hit = 1'b0;
        hist_val = '0;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            if (!hist_hit && hist[k].valid && (hist[k].addr == addr)) begin
                hist_hit = 1'b1;
                hist_val = hist[k].data;
            end
        end
    end

    // Held, historic and captured values are void in a flush or reset cycle.
    assign aux_ok    = !rst && !flush;
    assign in_hold   = (state == ST_HOLD) && aux_ok;
    assign fwd_ready = !rst && (addr != '0) && !in_hold && src_hit && src_rdy;

    always_comb begin
        data    = rf_data;
        pending = 1'b0;
        if (addr == '0) begin
            data = '0;
        end else if (rst) begin
            data = rf_data;
        end else if (in_hold) begin
            data = hold_data;
        end else if (src_hit) begin
            if (src_rdy) begin
                data = src_val;
            end else begin
                pending = 1'b1;
            end
        end else if (hist_hit && aux_ok) begin
            data = hist_val;
        end else if (cap_valid && aux_ok) begin
            data = cap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_data <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fwd_ready && stall_ex) begin
                        state     <= ST_HOLD;
                        hold_data <= src_val;
                    end
                end
                ST_HOLD: begin
                    if (!stall_ex) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hold_active = (state == ST_HOLD);

endmodule

// File: rtl/bypass_net.sv
// Operand bypass and load-use hazard unit beside EX: shared retire history and
// stall capture, plus one resolution port per source operand.
module bypass_net
    import bypass_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int AREG       = DEF_AREG,
    parameter int NUM_RS     = 2,
    parameter int NUM_SRC    = 2,
    parameter int HIST_DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    bypass_if.slave  bus
);

    hist_entry_t                 hist [HIST_DEPTH];
    logic                        cap_valid;
    logic [NUM_RS-1:0][XLEN-1:0] cap_data;
    logic [NUM_RS-1:0][XLEN-1:0] port_data;
    logic [NUM_RS-1:0]           port_pending;
    logic [NUM_RS-1:0]           port_hold;

    // Regfile readout is frozen on the first stalled cycle so a later
    // regfile change cannot alter operands of the instruction held in EX.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            cap_valid <= 1'b0;
        end else if (!bus.stall_ex) begin
            cap_valid <= 1'b0;
        end else if (!cap_valid) begin
            cap_valid <= 1'b1;
            cap_data  <= bus.rs_data_rf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist[k].valid <= 1'b0;
            end
        end else if (bus.retire_valid) begin
            hist[0] <= '{valid: (bus.retire_addr != '0),
                         addr:  bus.retire_addr,
                         data:  bus.retire_data};
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_RS; p++) begin : g_port
        bypass_port #(
            .XLEN       (XLEN),
            .AREG       (AREG),
            .NUM_SRC    (NUM_SRC),
            .HIST_DEPTH (HIST_DEPTH)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .addr        (bus.rs_addr[p]),
            .rf_data     (bus.rs_data_rf[p]),
            .src_valid   (bus.src_valid),
            .src_rd_addr (bus.src_rd_addr),
            .src_rd_data (bus.src_rd_data),
            .src_ready   (bus.src_ready),
            .hist        (hist),
            .cap_valid   (cap_valid),
            .cap_data    (cap_data[p]),
            .stall_ex    (bus.stall_ex),
            .flush       (bus.flush),
            .data        (port_data[p]),
            .pending     (port_pending[p]),
            .hold_active (port_hold[p])
        );
    end

    assign bus.rs_data_ex   = port_data;
    assign bus.hold_active  = port_hold;
    assign bus.hazard_stall = |port_pending;

endmodule

// File: tb/tb_bypass_net.sv
// Directed and randomized checks of bypass_net against a queue-based reference model.
module tb_bypass_net;

    localparam int XLEN       = 32;
    localparam int AREG       = 5;
    localparam int NUM_RS     = 2;
    localparam int NUM_SRC    = 2;
    localparam int HIST_DEPTH = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bypass_if #(.XLEN(XLEN), .AREG(AREG), .NUM_RS(NUM_RS), .NUM_SRC(NUM_SRC)) bus ();

    bypass_net #(
        .XLEN(XLEN), .AREG(AREG), .NUM_RS(NUM_RS), .NUM_SRC(NUM_SRC), .HIST_DEPTH(HIST_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit              v;
        logic [AREG-1:0] a;
        logic [XLEN-1:0] d;
    } hent_t;

    hent_t           mhist [$];
    bit              mcap_v;
    logic [XLEN-1:0] mcap    [NUM_RS];
    bit              mhold   [NUM_RS];
    logic [XLEN-1:0] mhold_d [NUM_RS];
    logic [XLEN-1:0] exp_d   [NUM_RS];
    bit              exp_pend[NUM_RS];
    bit              exp_fwd [NUM_RS];
    logic [XLEN-1:0] exp_fd  [NUM_RS];
    bit              ext_stall;
    int              n_tests;
    int              n_fail;
    logic [XLEN-1:0] first0, first1;
    bit              prev_stall;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic defaults();
        bus.rs_addr      = '0;
        bus.rs_data_rf   = '0;
        bus.src_valid    = '0;
        bus.src_rd_addr  = '0;
        bus.src_rd_data  = '0;
        bus.src_ready    = '0;
        bus.retire_valid = 1'b0;
        bus.retire_addr  = '0;
        bus.retire_data  = '0;
        bus.flush        = 1'b0;
        ext_stall        = 1'b0;
    endtask

    // Called at posedge+1 with inputs applied; predicts, drives stall_ex, checks at negedge.
    task automatic eval(input string tag);
        bit hz;
        hz = 1'b0;
        for (int p = 0; p < NUM_RS; p++) begin
            logic [AREG-1:0] a;
            int s, h;
            a = bus.rs_addr[p];
            s = -1;
            h = -1;
            exp_pend[p] = 1'b0;
            exp_fwd[p]  = 1'b0;
            exp_fd[p]   = '0;
            for (int i = 0; i < NUM_SRC; i++)
                if (s < 0 && bus.src_valid[i] && bus.src_rd_addr[i] == a) s = i;
            for (int k = 0; k < mhist.size(); k++)
                if (h < 0 && mhist[k].v && mhist[k].a == a) h = k;
            if (a == 0)                          exp_d[p] = '0;
            else if (rst)                        exp_d[p] = bus.rs_data_rf[p];
            else if (mhold[p] && !bus.flush)     exp_d[p] = mhold_d[p];
            else if (s >= 0) begin
                if (bus.src_ready[s]) begin
                    exp_d[p]   = bus.src_rd_data[s];
                    exp_fwd[p] = 1'b1;
                    exp_fd[p]  = bus.src_rd_data[s];
                end else begin
                    exp_pend[p] = 1'b1;
                    exp_d[p]    = bus.rs_data_rf[p];
                end
            end
            else if (h >= 0 && !bus.flush)       exp_d[p] = mhist[h].d;
            else if (mcap_v && !bus.flush)       exp_d[p] = mcap[p];
            else                                 exp_d[p] = bus.rs_data_rf[p];
            hz |= exp_pend[p];
        end
        bus.stall_ex = ext_stall | hz;
        #4;
        for (int p = 0; p < NUM_RS; p++) begin
            if (!exp_pend[p]) chk($sformatf("%s.data%0d", tag, p), bus.rs_data_ex[p], exp_d[p]);
            chk($sformatf("%s.hold%0d", tag, p), XLEN'(bus.hold_active[p]), XLEN'(mhold[p]));
        end
        chk($sformatf("%s.hazard", tag), XLEN'(bus.hazard_stall), XLEN'(hz));
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            mhist.delete();
            mcap_v = 1'b0;
            for (int p = 0; p < NUM_RS; p++) mhold[p] = 1'b0;
        end else if (bus.flush) begin
            foreach (mhist[k]) mhist[k].v = 1'b0;
            mcap_v = 1'b0;
            for (int p = 0; p < NUM_RS; p++) mhold[p] = 1'b0;
        end else begin
            for (int p = 0; p < NUM_RS; p++) begin
                if (mhold[p]) begin
                    if (!bus.stall_ex) mhold[p] = 1'b0;
                end else if (exp_fwd[p] && bus.stall_ex) begin
                    mhold[p]   = 1'b1;
                    mhold_d[p] = exp_fd[p];
                end
            end
            if (!bus.stall_ex) mcap_v = 1'b0;
            else if (!mcap_v) begin
                mcap_v = 1'b1;
                for (int p = 0; p < NUM_RS; p++) mcap[p] = bus.rs_data_rf[p];
            end
            if (bus.retire_valid) begin
                mhist.push_front('{v: (bus.retire_addr != 0), a: bus.retire_addr, d: bus.retire_data});
                if (mhist.size() > HIST_DEPTH) void'(mhist.pop_back());
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        eval(tag);
        adv();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mcap_v  = 1'b0;
        for (int p = 0; p < NUM_RS; p++) begin
            mhold[p] = 1'b0;
            mhold_d[p] = '0;
            mcap[p] = '0;
        end
        defaults();
        rst = 1'b1;
        bus.stall_ex = 1'b0;
        @(posedge clk);
        #1;
        bus.rs_addr[0] = 5'd4;
        bus.rs_data_rf[0] = 32'h0000_0444;
        eval("reset");
        chk("reset.rf", bus.rs_data_ex[0], 32'h0000_0444);
        adv();
        step("reset2");
        rst = 1'b0;
        chk("reset.hold", XLEN'(bus.hold_active), '0);

        // ALU chain
        defaults();
        bus.src_valid[0] = 1'b1; bus.src_ready[0] = 1'b1;
        bus.src_rd_addr[0] = 5'd5; bus.src_rd_data[0] = 32'h11;
        bus.rs_addr[0] = 5'd5;
        eval("alu");
        chk("alu.val", bus.rs_data_ex[0], 32'h11);
        chk("alu.nostall", XLEN'(bus.hazard_stall), '0);
        adv();

        // Load-use, stall follows hazard only
        defaults();
        bus.rs_addr[0] = 5'd7; bus.rs_data_rf[0] = 32'h77;
        bus.src_valid[0] = 1'b1; bus.src_rd_addr[0] = 5'd7; bus.src_ready[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            eval("lu_wait");
            chk("lu.stall", XLEN'(bus.hazard_stall), 1);
            adv();
        end
        bus.src_ready[0] = 1'b1; bus.src_rd_data[0] = 32'hDEAD_BEEF;
        eval("lu_ready");
        chk("lu.fwd", bus.rs_data_ex[0], 32'hDEAD_BEEF);
        chk("lu.release", XLEN'(bus.hazard_stall), '0);
        adv();

        // Load-use arriving under an external stall -> HOLD
        bus.src_ready[0] = 1'b0;
        step("luh_wait");
        step("luh_wait");
        bus.src_ready[0] = 1'b1; bus.src_rd_data[0] = 32'hDEAD_BEEF; ext_stall = 1'b1;
        eval("luh_ready");
        chk("luh.fwd", bus.rs_data_ex[0], 32'hDEAD_BEEF);
        adv();
        bus.src_rd_data[0] = 32'h1234;
        eval("luh_held");
        chk("luh.held", bus.rs_data_ex[0], 32'hDEAD_BEEF);
        chk("luh.active", XLEN'(bus.hold_active[0]), 1);
        adv();
        ext_stall = 1'b0;
        eval("luh_consume");
        chk("luh.consume", bus.rs_data_ex[0], 32'hDEAD_BEEF);
        adv();
        eval("luh_after");
        chk("luh.idle", XLEN'(bus.hold_active[0]), '0);
        chk("luh.new", bus.rs_data_ex[0], 32'h1234);
        adv();

        // Youngest wins
        defaults();
        bus.src_valid = 2'b11; bus.src_ready = 2'b11;
        bus.src_rd_addr[0] = 5'd3; bus.src_rd_data[0] = 32'hA;
        bus.src_rd_addr[1] = 5'd3; bus.src_rd_data[1] = 32'hB;
        bus.rs_addr[0] = 5'd3;
        eval("young");
        chk("young.val", bus.rs_data_ex[0], 32'hA);
        adv();
        bus.src_ready[0] = 1'b0;
        eval("young_pend");
        chk("young.stall", XLEN'(bus.hazard_stall), 1);
        adv();
        defaults();
        step("settle");

        // History forwarding, x0 retire never forwarded
        bus.retire_valid = 1'b1; bus.retire_addr = 5'd9; bus.retire_data = 32'h99;
        step("hist_wr");
        bus.retire_valid = 1'b0;
        bus.rs_addr[0] = 5'd9; bus.rs_data_rf[0] = 32'h0;
        eval("hist_rd");
        chk("hist.val", bus.rs_data_ex[0], 32'h99);
        adv();
        bus.retire_valid = 1'b1; bus.retire_addr = 5'd0; bus.retire_data = 32'h55;
        step("hist_x0");
        bus.retire_valid = 1'b0;
        eval("hist_x0rd");
        chk("hist.x0", bus.rs_data_ex[0], 32'h0);
        adv();

        // Stall capture
        defaults();
        bus.rs_addr[0] = 5'd4; bus.rs_addr[1] = 5'd6;
        ext_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.rs_data_rf[0] = $urandom;
            bus.rs_data_rf[1] = $urandom;
            if (c == 0) begin
                first0 = bus.rs_data_rf[0];
                first1 = bus.rs_data_rf[1];
            end
            eval("cap");
            chk("cap.p0", bus.rs_data_ex[0], first0);
            chk("cap.p1", bus.rs_data_ex[1], first1);
            adv();
        end
        ext_stall = 1'b0;
        bus.rs_data_rf[0] = first0 ^ 32'hFFFF_0000;
        step("cap_release");
        eval("cap_after");
        chk("cap.rf", bus.rs_data_ex[0], first0 ^ 32'hFFFF_0000);
        adv();

        // Flush and reset during HOLD
        for (int r = 0; r < 2; r++) begin
            defaults();
            bus.rs_addr[0] = 5'd7;
            bus.src_valid[0] = 1'b1; bus.src_ready[0] = 1'b1;
            bus.src_rd_addr[0] = 5'd7; bus.src_rd_data[0] = 32'h00C0_FFEE;
            ext_stall = 1'b1;
            step("kill_enter");
            bus.src_valid[0] = 1'b0; bus.rs_data_rf[0] = 32'h0707;
            if (r == 0) bus.flush = 1'b1; else rst = 1'b1;
            eval("kill");
            chk("kill.rf", bus.rs_data_ex[0], 32'h0707);
            adv();
            bus.flush = 1'b0; rst = 1'b0; ext_stall = 1'b0;
            eval("kill_after");
            chk("kill.idle", XLEN'(bus.hold_active[0]), '0);
            chk("kill.rf2", bus.rs_data_ex[0], 32'h0707);
            adv();
        end

        // Randomized traffic
        defaults();
        prev_stall = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!prev_stall)
                for (int p = 0; p < NUM_RS; p++) bus.rs_addr[p] = AREG'($urandom_range(0, 3));
            for (int p = 0; p < NUM_RS; p++) bus.rs_data_rf[p] = $urandom;
            for (int s = 0; s < NUM_SRC; s++) begin
                bus.src_valid[s]   = 1'($urandom_range(0, 1));
                bus.src_rd_addr[s] = AREG'($urandom_range(0, 3));
                bus.src_rd_data[s] = $urandom;
                bus.src_ready[s]   = ($urandom_range(0, 3) != 0);
            end
            bus.retire_valid = 1'($urandom_range(0, 1));
            bus.retire_addr  = AREG'($urandom_range(0, 3));
            bus.retire_data  = $urandom;
            bus.flush        = ($urandom_range(0, 19) == 0);
            rst              = ($urandom_range(0, 49) == 0);
            ext_stall        = ($urandom_range(0, 3) == 0);
            eval("rnd");
            prev_stall = bus.stall_ex;
            adv();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
